// File: rtl/uart_baud_sched.sv
// Baud-rate tick scheduler: derives the oversample and bit ticks from the active divisor.
// New divisors are deferred while a frame is in flight, so each frame uses a single rate.
module uart_baud_sched #(
    parameter int OVS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dvsr,
    input  logic        uart_idle,
    output logic        tick,
    output logic        bit_tick,
    output logic [15:0] dvsr_active,
    output logic        pending,
    output logic        applied,
    output logic        halted
);

    localparam int SUB_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       dvsr_active_reg, dvsr_active_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [SUB_W-1:0]  sub_reg, sub_next;
    logic              applied_reg, applied_next;

    logic              chg;
    logic              load;
    logic              wrap;

    assign chg  = (dvsr != dvsr_active_reg);
    assign wrap = (cnt_reg == dvsr_active_reg);

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_HALT;
            dvsr_active_reg <= 16'd0;
            cnt_reg         <= 16'd0;
            sub_reg         <= '0;
            applied_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dvsr_active_reg <= dvsr_active_next;
            cnt_reg         <= cnt_next;
            sub_reg         <= sub_next;
            applied_reg     <= applied_next;
        end
    end

    // Next-state logic. A halted generator has no frame in flight, so it loads at once.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_HALT: begin
                if (chg) begin
                    load = 1'b1;
                end
            end
            ST_RUN: begin
                if (chg) begin
                    if (uart_idle) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!chg) begin
                    state_next = ST_RUN;
                end else if (uart_idle) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
        if (load) begin
            state_next = (dvsr == 16'd0) ? ST_HALT : ST_RUN;
        end
    end

    // Datapath next values; a load restarts both counters from zero.
    always_comb begin
        dvsr_active_next = dvsr_active_reg;
        cnt_next         = cnt_reg;
        sub_next         = sub_reg;
        applied_next     = 1'b0;
        if (load) begin
            dvsr_active_next = dvsr;
            cnt_next         = 16'd0;
            sub_next         = '0;
            applied_next     = 1'b1;
        end else if (state_reg != ST_HALT) begin
            if (wrap) begin
                cnt_next = 16'd0;
                sub_next = sub_reg + 1'b1;
            end else begin
                cnt_next = cnt_reg + 16'd1;
            end
        end
    end

    // Outputs are decoded from registers only.
    always_comb begin
        tick        = (state_reg != ST_HALT) && wrap;
        bit_tick    = tick && (sub_reg == SUB_LAST);
        dvsr_active = dvsr_active_reg;
        pending     = (state_reg == ST_PEND);
        halted      = (state_reg == ST_HALT);
        applied     = applied_reg;
    end

endmodule
